dem_mode_ctrl: RTL and testbench

- Sequencing controller for the 6-element ISI/mismatch-shaping DEM core.
- Accepts run-time bypass-mode change requests (ISI_SEL, MIS_SEL) over a valid/ready handshake.
- Applies each change glitch-free: mute the core input to mid-scale, hold the core's loop filters in reset, apply the new mode, then let the loops settle before un-muting.
- Also watches the core's SV output for a stuck loop and re-initialises the core automatically.

---
 rtl/dem_ctrl_pkg.sv | 33 +++
 rtl/dem_stuck_wd.sv | 75 +++++++
 rtl/dem_mode_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_dem_mode_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dem_ctrl_pkg.sv
// Shared types and constants for the DEM mode-sequencing controller.
//   state_e   : controller phases (RUN, MUTE, FLUSH, SETTLE)
//   mode_t    : bypass mode {isi_sel, mis_sel} as driven to the DEM core
//   MODE_RESET: full bypass, the mode the core wakes up in
//   MID_CODE_DEF / V_MAX_DEF: default mid-scale and full-scale input codes
package dem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MUTE   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  typedef struct packed {
    logic isi_sel;
    logic mis_sel;
  } mode_t;

  localparam mode_t MODE_RESET = 2'b11;

  localparam logic signed [3:0] MID_CODE_DEF = 4'sd3;
  localparam logic signed [3:0] V_MAX_DEF    = 4'sd6;

  // Pack the two request bits into the mode encoding used by the core.
  function automatic mode_t mk_mode(input logic isi, input logic mis);
    mode_t m;
    m.isi_sel = isi;
    m.mis_sel = mis;
    return m;
  endfunction

endpackage

// File: rtl/dem_stuck_wd.sv
// Stuck-loop watchdog for the DEM core.
// Counts consecutive enabled cycles in which the core's SV output did not
// change while the mismatch shaper is active and the input is neither empty
// nor full scale (at 0 / V_MAX a frozen SV is legitimate).
//   clk, rstn : clock, synchronous active-low reset
//   en        : count enable (controller in RUN and clk_en)
//   clr       : clears the run counter (controller outside RUN)
//   sv_in     : SVout from the core
//   v_in      : element count currently fed to the modulator path
//   mis_sel   : current MIS bypass (1 disables the watchdog)
//   trip      : combinational, high on the enabled cycle that reaches WD_LIMIT
module dem_stuck_wd
  import dem_ctrl_pkg::*;
#(
  parameter int unsigned       WD_LIMIT = 64,
  parameter int unsigned       CNT_W    = 8,
  parameter logic signed [3:0] V_MAX    = V_MAX_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              clr,
  input  logic [5:0]        sv_in,
  input  logic signed [3:0] v_in,
  input  logic              mis_sel,
  output logic              trip
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_LIMIT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};

  logic [5:0]       sv_prev_q, sv_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stuck_s;

  assign stuck_s = (sv_in == sv_prev_q) && !mis_sel &&
                   (v_in != 4'sd0) && (v_in != V_MAX);

  // Compare register and run counter next-state; trip ends the run.
  always_comb begin
    sv_prev_d = sv_prev_q;
    cnt_d     = cnt_q;
    trip      = 1'b0;
    if (clr) begin
      cnt_d = ZERO;
    end else if (en) begin
      sv_prev_d = sv_in;
      if (stuck_s) begin
        if (cnt_q == WD_LAST) begin
          trip  = 1'b1;
          cnt_d = ZERO;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        cnt_d = ZERO;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sv_prev_q <= 6'd0;
      cnt_q     <= ZERO;
    end else begin
      sv_prev_q <= sv_prev_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/dem_mode_ctrl.sv
// Mode-change sequencer for the 6-element ISI/mismatch-shaping DEM core.
// A bypass-mode change is applied as MUTE (mid-scale input) -> FLUSH (core
// loop filters held in reset, new mode applied) -> SETTLE (mid-scale input,
// loops running) -> RUN. A stuck-SV watchdog re-flushes the core in place.
//   clk, rstn            : clock, synchronous active-low reset
//   clk_en               : sample enable shared with the core
//   v_in                 : modulator element count; v_out : V to the core
//   cfg_valid/cfg_ready  : mode request handshake, cfg_isi_sel/cfg_mis_sel
//   cfg_done             : one-cycle pulse once the requested mode runs
//   sv_in                : SVout from the core, watched for a stuck loop
//   wd_clr               : clears wd_flag
//   core_rstn, isi_sel, mis_sel : registered core controls
//   busy                 : controller not in RUN
//   wd_flag, wd_count    : sticky trip flag and saturating trip count
module dem_mode_ctrl
  import dem_ctrl_pkg::*;
#(
  parameter int unsigned       MUTE_CYC   = 4,
  parameter int unsigned       FLUSH_CYC  = 2,
  parameter int unsigned       SETTLE_CYC = 8,
  parameter int unsigned       WD_LIMIT   = 64,
  parameter logic signed [3:0] MID_CODE   = MID_CODE_DEF,
  parameter logic signed [3:0] V_MAX      = V_MAX_DEF,
  parameter int unsigned       CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clk_en,
  input  logic signed [3:0] v_in,
  input  logic              cfg_valid,
  input  logic              cfg_isi_sel,
  input  logic              cfg_mis_sel,
  output logic              cfg_ready,
  output logic              cfg_done,
  input  logic [5:0]        sv_in,
  input  logic              wd_clr,
  output logic signed [3:0] v_out,
  output logic              core_rstn,
  output logic              isi_sel,
  output logic              mis_sel,
  output logic              busy,
  output logic              wd_flag,
  output logic [3:0]        wd_count
);

  localparam logic [CNT_W-1:0] MUTE_LAST   = CNT_W'(MUTE_CYC - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO        = {CNT_W{1'b0}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mode_t             mode_q, mode_d;     // mode currently applied to the core
  mode_t             req_q, req_d;       // mode waiting to be applied in FLUSH
  logic              pend_q, pend_d;     // a request owes a cfg_done
  logic signed [3:0] v_out_q, v_out_d;
  logic              core_rstn_q, core_rstn_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              cfg_done_q, cfg_done_d;
  logic              busy_q, busy_d;
  logic              wd_flag_q, wd_flag_d;
  logic [3:0]        wd_count_q, wd_count_d;

  mode_t             cfg_mode_s;
  logic              accept_s;
  logic              trip_s;
  logic              wd_en_s;
  logic              wd_rst_s;

  assign cfg_mode_s = mk_mode(cfg_isi_sel, cfg_mis_sel);
  // cfg_ready_q is high exactly while in RUN.
  assign accept_s   = cfg_valid && cfg_ready_q;
  assign wd_en_s    = (state_q == ST_RUN) && clk_en;
  assign wd_rst_s   = (state_q != ST_RUN);

  dem_stuck_wd #(
    .WD_LIMIT (WD_LIMIT),
    .CNT_W    (CNT_W),
    .V_MAX    (V_MAX)
  ) u_stuck_wd (
    .clk     (clk),
    .rstn    (rstn),
    .en      (wd_en_s),
    .clr     (wd_rst_s),
    .sv_in   (sv_in),
    .v_in    (v_in),
    .mis_sel (mode_q.mis_sel),
    .trip    (trip_s)
  );

  // Next-state, phase counter, mode latching and watchdog bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    req_d      = req_q;
    pend_d     = pend_q;
    cfg_done_d = 1'b0;
    wd_count_d = wd_count_q;
    if (wd_clr) begin
      wd_flag_d = 1'b0;
    end else begin
      wd_flag_d = wd_flag_q;
    end
    case (state_q)
      ST_RUN: begin
        // A request outranks a coincident trip; the trip is simply dropped.
        if (accept_s) begin
          if (cfg_mode_s == mode_q) begin
            cfg_done_d = 1'b1;
          end else begin
            req_d   = cfg_mode_s;
            pend_d  = 1'b1;
            state_d = ST_MUTE;
            cnt_d   = ZERO;
          end
        end else if (trip_s) begin
          state_d   = ST_FLUSH;
          cnt_d     = ZERO;
          wd_flag_d = 1'b1;
          if (wd_count_q != 4'hF) begin
            wd_count_d = wd_count_q + 4'd1;
          end else begin
            wd_count_d = wd_count_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MUTE: begin
        if (clk_en) begin
          if (cnt_q == MUTE_LAST) begin
            state_d = ST_FLUSH;
            cnt_d   = ZERO;
            mode_d  = req_q;   // new mode lands together with core reset
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_FLUSH: begin
        // Core reset length is in raw clocks, independent of clk_en.
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = ZERO;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_SETTLE: begin
        if (clk_en) begin
          if (cnt_q == SETTLE_LAST) begin
            state_d    = ST_RUN;
            cnt_d      = ZERO;
            cfg_done_d = pend_q;
            pend_d     = 1'b0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_FLUSH;
        cnt_d   = ZERO;
      end
    endcase
  end

  // Output next values follow the next state so registered outputs line up
  // with the state they describe.
  always_comb begin
    core_rstn_d = (state_d != ST_FLUSH);
    cfg_ready_d = (state_d == ST_RUN);
    busy_d      = (state_d != ST_RUN);
    if (state_d != ST_RUN) begin
      v_out_d = MID_CODE;
    end else if (clk_en) begin
      v_out_d = v_in;
    end else begin
      v_out_d = v_out_q;
    end
  end

  // State and output registers; reset parks the core in full-bypass flush.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_FLUSH;
      cnt_q       <= ZERO;
      mode_q      <= MODE_RESET;
      req_q       <= MODE_RESET;
      pend_q      <= 1'b0;
      v_out_q     <= MID_CODE;
      core_rstn_q <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      busy_q      <= 1'b1;
      wd_flag_q   <= 1'b0;
      wd_count_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      req_q       <= req_d;
      pend_q      <= pend_d;
      v_out_q     <= v_out_d;
      core_rstn_q <= core_rstn_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_done_q  <= cfg_done_d;
      busy_q      <= busy_d;
      wd_flag_q   <= wd_flag_d;
      wd_count_q  <= wd_count_d;
    end
  end

  assign v_out     = v_out_q;
  assign core_rstn = core_rstn_q;
  assign isi_sel   = mode_q.isi_sel;
  assign mis_sel   = mode_q.mis_sel;
  assign cfg_ready = cfg_ready_q;
  assign cfg_done  = cfg_done_q;
  assign busy      = busy_q;
  assign wd_flag   = wd_flag_q;
  assign wd_count  = wd_count_q;

endmodule

// File: tb/tb_dem_mode_ctrl.sv
// Self-checking bench for dem_mode_ctrl. Expected cfg_done cycles and v_out
// samples are queued when stimulus is applied and compared when the DUT
// produces them; phase lengths are measured from the core-facing outputs.
module tb_dem_mode_ctrl;

  localparam int MID      = 3;
  localparam int MUTE_N   = 4;
  localparam int FLUSH_N  = 2;
  localparam int SETTLE_N = 8;
  localparam int WD_N     = 64;

  logic              clk = 1'b0;
  logic              rstn;
  logic              clk_en;
  logic signed [3:0] v_in;
  logic              cfg_valid;
  logic              cfg_isi_sel;
  logic              cfg_mis_sel;
  logic              cfg_ready;
  logic              cfg_done;
  logic [5:0]        sv_in;
  logic              wd_clr;
  logic signed [3:0] v_out;
  logic              core_rstn;
  logic              isi_sel;
  logic              mis_sel;
  logic              busy;
  logic              wd_flag;
  logic [3:0]        wd_count;

  dem_mode_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .clk_en      (clk_en),
    .v_in        (v_in),
    .cfg_valid   (cfg_valid),
    .cfg_isi_sel (cfg_isi_sel),
    .cfg_mis_sel (cfg_mis_sel),
    .cfg_ready   (cfg_ready),
    .cfg_done    (cfg_done),
    .sv_in       (sv_in),
    .wd_clr      (wd_clr),
    .v_out       (v_out),
    .core_rstn   (core_rstn),
    .isi_sel     (isi_sel),
    .mis_sel     (mis_sel),
    .busy        (busy),
    .wd_flag     (wd_flag),
    .wd_count    (wd_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_chk = 0;
  int         n_err = 0;
  int         done_q[$];
  int         vq[$];
  int         flush_n, ms_n, vmid_bad, done_seen;
  logic [1:0] flush_mode;
  bit         en_toggle = 1'b0;
  bit         sv_run = 1'b1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    flush_n   = 0;
    ms_n      = 0;
    vmid_bad  = 0;
    done_seen = 0;
  endtask

  // One clock: observe outputs at the falling edge, then update free-running stimulus.
  task automatic tick();
    @(negedge clk);
    if (!core_rstn) begin
      flush_n++;
      flush_mode = {isi_sel, mis_sel};
    end else if (busy) begin
      ms_n++;
      if (v_out != 4'(MID)) vmid_bad++;
    end
    if (cfg_done) begin
      done_seen++;
      check_val("done_expected", int'(done_q.size() > 0), 1);
      if (done_q.size() > 0) check_val("done_cycle", cyc, done_q.pop_front());
    end
    if (en_toggle) clk_en = ~clk_en;
    if (sv_run) sv_in = sv_in + 6'd1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < budget);
    check_val("idle_reached", int'(busy), 0);
  endtask

  // Issue one request; lat is the expected cycle offset of cfg_done from the
  // acceptance edge (cycle count: acceptance cycle plus the full sequence).
  task automatic send_req(input logic isi, input logic mis, input int lat, input bit exp_done);
    tick();
    check_val("cfg_ready", int'(cfg_ready), 1);
    cfg_isi_sel = isi;
    cfg_mis_sel = mis;
    cfg_valid   = 1'b1;
    @(posedge clk);
    #1;
    if (exp_done) done_q.push_back(cyc + lat);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int last_v;
    int exp_v;
    int trip_n;
    rstn = 1'b0; clk_en = 1'b1; v_in = 4'sd0; cfg_valid = 1'b0;
    cfg_isi_sel = 1'b0; cfg_mis_sel = 1'b0; sv_in = 6'd0; wd_clr = 1'b0;
    clr_stats();

    // Reset values
    repeat (3) tick();
    check_val("rst_core_rstn", int'(core_rstn), 0);
    check_val("rst_mode", int'({isi_sel, mis_sel}), 3);
    check_val("rst_v_out", int'(v_out), MID);
    check_val("rst_ready", int'(cfg_ready), 0);
    check_val("rst_done", int'(cfg_done), 0);
    check_val("rst_busy", int'(busy), 1);
    check_val("rst_wd_flag", int'(wd_flag), 0);
    check_val("rst_wd_count", int'(wd_count), 0);

    // Boot: core reset held through the release cycle and one more clock, then settle
    rstn = 1'b1;
    tick();
    check_val("boot_flush_hold", int'(core_rstn), 0);
    clr_stats();
    tick();
    check_val("boot_flush_end", int'(core_rstn), 1);
    wait_idle(40);
    check_val("boot_settle_len", ms_n, SETTLE_N);
    check_val("boot_settle_mid", vmid_bad, 0);
    check_val("boot_mode", int'({isi_sel, mis_sel}), 3);

    // Mode change 11 -> 00 with v_in = 5
    clr_stats();
    v_in = 4'sd5;
    send_req(1'b0, 1'b0, MUTE_N + FLUSH_N + SETTLE_N, 1'b1);
    wait_idle(60);
    tick();
    check_val("chg_flush_len", flush_n, FLUSH_N);
    check_val("chg_flush_mode", int'(flush_mode), 0);
    check_val("chg_mute_settle", ms_n, MUTE_N + SETTLE_N);
    check_val("chg_mid", vmid_bad, 0);
    check_val("chg_done_cnt", done_seen, 1);
    check_val("chg_mode", int'({isi_sel, mis_sel}), 0);
    check_val("chg_v_out", int'(v_out), 5);

    // v_out follows v_in with one cycle latency, holding when clk_en is low
    last_v = 5;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (vq.size() > 0) check_val("v_follow", int'(v_out), vq.pop_front());
      v_in   = 4'($urandom_range(0, 6));
      clk_en = (i % 3 != 2);
      exp_v  = clk_en ? int'(v_in) : last_v;
      last_v = exp_v;
      vq.push_back(exp_v);
    end
    tick();
    check_val("v_follow_last", int'(v_out), vq.pop_front());
    clk_en = 1'b1;

    // Same-mode request: immediate done, no sequence
    clr_stats();
    send_req(1'b0, 1'b0, 0, 1'b1);
    repeat (4) tick();
    check_val("same_done_cnt", done_seen, 1);
    check_val("same_no_flush", flush_n, 0);
    check_val("same_no_mute", ms_n, 0);

    // Mode change 00 -> 10 with clk_en alternating, low on the first clock after acceptance
    clr_stats();
    send_req(1'b1, 1'b0, 2 * MUTE_N + FLUSH_N + 2 * SETTLE_N, 1'b1);
    en_toggle = 1'b1;
    wait_idle(80);
    en_toggle = 1'b0;
    clk_en    = 1'b1;
    tick();
    check_val("tog_mute_settle", ms_n, 2 * (MUTE_N + SETTLE_N));
    check_val("tog_flush_len", flush_n, FLUSH_N);
    check_val("tog_flush_mode", int'(flush_mode), 2);
    check_val("tog_done_cnt", done_seen, 1);

    // Back to mode 00, then freeze SV with v_in = 4
    send_req(1'b0, 1'b0, MUTE_N + FLUSH_N + SETTLE_N, 1'b1);
    wait_idle(60);
    clr_stats();
    v_in   = 4'sd4;
    sv_run = 1'b0;
    sv_in  = 6'd40;
    tick();
    sv_in  = 6'b001111;
    trip_n = 0;
    while (trip_n < 100) begin
      tick();
      trip_n++;
      if (busy) break;
    end
    // First frozen sample differs from the previous one, then WD_N unchanged cycles
    check_val("wd_trip_cycles", trip_n, WD_N + 1);
    check_val("wd_flag_set", int'(wd_flag), 1);
    check_val("wd_count_1", int'(wd_count), 1);
    wait_idle(60);
    check_val("wd_flush_len", flush_n, FLUSH_N);
    check_val("wd_mode_kept", int'(flush_mode), 0);
    check_val("wd_no_done", done_seen, 0);

    // Full-scale input: frozen SV is legitimate, no trip
    v_in = 4'sd6;
    clr_stats();
    wd_clr = 1'b1;
    tick();
    wd_clr = 1'b0;
    check_val("wd_clr", int'(wd_flag), 0);
    repeat (80) tick();
    check_val("vmax_no_trip", ms_n + flush_n, 0);
    check_val("vmax_wd_count", int'(wd_count), 1);

    // wd_clr coincident with a trip: set wins
    v_in = 4'sd4;
    repeat (WD_N - 1) tick();
    wd_clr = 1'b1;
    tick();
    wd_clr = 1'b0;
    check_val("wd2_trip", int'(busy), 1);
    check_val("wd2_set_wins", int'(wd_flag), 1);
    check_val("wd2_count", int'(wd_count), 2);
    wait_idle(60);
    v_in   = 4'sd6;
    sv_run = 1'b1;

    // Reset during MUTE discards the request
    clr_stats();
    send_req(1'b0, 1'b1, 0, 1'b0);
    tick();
    tick();
    check_val("mid_req_muted", int'(v_out), MID);
    rstn = 1'b0;
    tick();
    check_val("mid_rst_core_rstn", int'(core_rstn), 0);
    check_val("mid_rst_mode", int'({isi_sel, mis_sel}), 3);
    check_val("mid_rst_busy", int'(busy), 1);
    check_val("mid_rst_wd_count", int'(wd_count), 0);
    check_val("mid_rst_wd_flag", int'(wd_flag), 0);
    rstn = 1'b1;
    wait_idle(60);
    tick();
    check_val("mid_rst_mode_run", int'({isi_sel, mis_sel}), 3);
    check_val("mid_rst_no_done", done_seen, 0);

    check_val("done_queue_empty", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
